// File: rtl/operand_load_stage.sv
// rtl/operand_load_stage.sv - per-lane operand fetch, bypass select and one-entry output slot
// Optional feature macro: LOAD_ZC_FWD_EN (zero-cycle forward buses join operand select).
module operand_load_stage #(
    parameter int NUM_UOPS    = 2,
    parameter int NUM_WBS     = 3,
    parameter int NUM_ZC_FWDS = 2,
    parameter int NUM_FUS     = 4,
    parameter int TAG_W       = 6,
    parameter int DATA_W      = 32,
    parameter int SQN_W       = 6,
    parameter int SIDE_W      = 40
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_UOPS-1:0]                   IN_valid,
    output logic [NUM_UOPS-1:0]                   OUT_ready,
    input  logic [NUM_UOPS*TAG_W-1:0]             IN_tagA,
    input  logic [NUM_UOPS*TAG_W-1:0]             IN_tagB,
    input  logic [NUM_UOPS-1:0]                   IN_immA,
    input  logic [NUM_UOPS-1:0]                   IN_immB,
    input  logic [NUM_UOPS*DATA_W-1:0]            IN_imm,
    input  logic [NUM_UOPS*DATA_W-1:0]            IN_pc,
    input  logic [NUM_UOPS*SQN_W-1:0]             IN_sqN,
    input  logic [NUM_UOPS*$clog2(NUM_FUS)-1:0]   IN_fu,
    input  logic [NUM_UOPS*SIDE_W-1:0]            IN_side,
    output logic [2*NUM_UOPS-1:0]                 OUT_rfReadValid,
    output logic [2*NUM_UOPS*TAG_W-1:0]           OUT_rfReadAddr,
    input  logic [2*NUM_UOPS*DATA_W-1:0]          IN_rfReadData,
    input  logic [NUM_WBS-1:0]                    IN_wbValid,
    input  logic [NUM_WBS*TAG_W-1:0]              IN_wbTag,
    input  logic [NUM_WBS*DATA_W-1:0]             IN_wbData,
    input  logic [NUM_ZC_FWDS-1:0]                IN_zcValid,
    input  logic [NUM_ZC_FWDS*TAG_W-1:0]          IN_zcTag,
    input  logic [NUM_ZC_FWDS*DATA_W-1:0]         IN_zcData,
    input  logic                                  IN_invalidate,
    input  logic [SQN_W-1:0]                      IN_invalidateSqN,
    output logic [NUM_UOPS-1:0]                   OUT_valid,
    input  logic [NUM_UOPS-1:0]                   IN_fuReady,
    output logic [NUM_UOPS*DATA_W-1:0]            OUT_srcA,
    output logic [NUM_UOPS*DATA_W-1:0]            OUT_srcB,
    output logic [NUM_UOPS*DATA_W-1:0]            OUT_imm,
    output logic [NUM_UOPS*DATA_W-1:0]            OUT_pc,
    output logic [NUM_UOPS*SQN_W-1:0]             OUT_sqN,
    output logic [NUM_UOPS*$clog2(NUM_FUS)-1:0]   OUT_fu,
    output logic [NUM_UOPS*SIDE_W-1:0]            OUT_side,
    output logic [NUM_UOPS*NUM_FUS-1:0]           OUT_enableFU
);
    localparam int FU_W = $clog2(NUM_FUS);
    localparam logic [NUM_FUS-1:0] FU_ONE = 1;

    // Later assignments override earlier ones, so ascending wb and descending zc
    // loops give "highest wb wins" and "lowest zc wins".
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic              use_imm,
        input logic [DATA_W-1:0] imm_val,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] v;
        v = rf_data;
        for (int w = 0; w < NUM_WBS; w++)
            if (IN_wbValid[w] && IN_wbTag[w*TAG_W +: TAG_W] == tag)
                v = IN_wbData[w*DATA_W +: DATA_W];
`ifdef LOAD_ZC_FWD_EN
        for (int z = NUM_ZC_FWDS - 1; z >= 0; z--)
            if (IN_zcValid[z] && IN_zcTag[z*TAG_W +: TAG_W] == tag)
                v = IN_zcData[z*DATA_W +: DATA_W];
`endif
        if (tag == '0)
            v = '0;
        if (use_imm)
            v = imm_val;
        return v;
    endfunction

    function automatic logic is_younger(input logic [SQN_W-1:0] sqn, input logic [SQN_W-1:0] ref_sqn);
        logic [SQN_W-1:0] d;
        d = sqn - ref_sqn;
        return !d[SQN_W-1] && (d != '0);
    endfunction

`ifndef LOAD_ZC_FWD_EN
    logic zc_unused;
    assign zc_unused = ^{IN_zcValid, IN_zcTag, IN_zcData};
`endif

    for (genvar i = 0; i < NUM_UOPS; i++) begin : g_lane
        logic [TAG_W-1:0]  tag_a, tag_b;
        logic [SQN_W-1:0]  in_sqn;
        logic [DATA_W-1:0] op_a, op_b;
        logic              ready, accept;
        logic              slot_valid;
        logic [DATA_W-1:0] r_src_a, r_src_b, r_imm, r_pc;
        logic [SQN_W-1:0]  r_sqn;
        logic [FU_W-1:0]   r_fu;
        logic [SIDE_W-1:0] r_side;

        assign tag_a  = IN_tagA[i*TAG_W +: TAG_W];
        assign tag_b  = IN_tagB[i*TAG_W +: TAG_W];
        assign in_sqn = IN_sqN[i*SQN_W +: SQN_W];

        assign OUT_rfReadValid[i]                            = IN_valid[i] & ~IN_immA[i];
        assign OUT_rfReadValid[i+NUM_UOPS]                   = IN_valid[i] & ~IN_immB[i];
        assign OUT_rfReadAddr[i*TAG_W +: TAG_W]              = tag_a;
        assign OUT_rfReadAddr[(i+NUM_UOPS)*TAG_W +: TAG_W]   = tag_b;

        always_comb begin
            op_a = pick_operand(IN_immA[i], IN_pc[i*DATA_W +: DATA_W], tag_a,
                                IN_rfReadData[i*DATA_W +: DATA_W]);
            op_b = pick_operand(IN_immB[i], IN_imm[i*DATA_W +: DATA_W], tag_b,
                                IN_rfReadData[(i+NUM_UOPS)*DATA_W +: DATA_W]);
        end

        assign ready  = ~slot_valid | IN_fuReady[i];
        assign accept = IN_valid[i] & ready & ~(IN_invalidate & is_younger(in_sqn, IN_invalidateSqN));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_valid <= 1'b0;
                r_src_a    <= '0;
                r_src_b    <= '0;
                r_imm      <= '0;
                r_pc       <= '0;
                r_sqn      <= '0;
                r_fu       <= '0;
                r_side     <= '0;
            end else if (accept) begin
                slot_valid <= 1'b1;
                r_src_a    <= op_a;
                r_src_b    <= op_b;
                r_imm      <= IN_imm[i*DATA_W +: DATA_W];
                r_pc       <= IN_pc[i*DATA_W +: DATA_W];
                r_sqn      <= in_sqn;
                r_fu       <= IN_fu[i*FU_W +: FU_W];
                r_side     <= IN_side[i*SIDE_W +: SIDE_W];
            end else if (ready || (IN_invalidate && is_younger(r_sqn, IN_invalidateSqN))) begin
                slot_valid <= 1'b0;
            end
        end

        assign OUT_ready[i]                     = ready;
        assign OUT_valid[i]                     = slot_valid;
        assign OUT_srcA[i*DATA_W +: DATA_W]     = r_src_a;
        assign OUT_srcB[i*DATA_W +: DATA_W]     = r_src_b;
        assign OUT_imm[i*DATA_W +: DATA_W]      = r_imm;
        assign OUT_pc[i*DATA_W +: DATA_W]       = r_pc;
        assign OUT_sqN[i*SQN_W +: SQN_W]        = r_sqn;
        assign OUT_fu[i*FU_W +: FU_W]           = r_fu;
        assign OUT_side[i*SIDE_W +: SIDE_W]     = r_side;
        assign OUT_enableFU[i*NUM_FUS +: NUM_FUS] = slot_valid ? (FU_ONE << r_fu) : '0;
    end
endmodule

// File: tb/tb_operand_load_stage.sv
// tb/tb_operand_load_stage.sv - directed and randomized checks of operand_load_stage
module tb_operand_load_stage;
    localparam int NU = 2, NW = 3, NZ = 2, NF = 4, TW = 6, DW = 32, SW = 6, SDW = 40, FW = 2;

    logic clk, rst;
    logic [NU-1:0]       IN_valid, OUT_ready, IN_immA, IN_immB, OUT_valid, IN_fuReady;
    logic [NU*TW-1:0]    IN_tagA, IN_tagB;
    logic [NU*DW-1:0]    IN_imm, IN_pc, OUT_srcA, OUT_srcB, OUT_imm, OUT_pc;
    logic [NU*SW-1:0]    IN_sqN, OUT_sqN;
    logic [NU*FW-1:0]    IN_fu, OUT_fu;
    logic [NU*SDW-1:0]   IN_side, OUT_side;
    logic [2*NU-1:0]     OUT_rfReadValid;
    logic [2*NU*TW-1:0]  OUT_rfReadAddr;
    logic [2*NU*DW-1:0]  IN_rfReadData;
    logic [NW-1:0]       IN_wbValid;
    logic [NW*TW-1:0]    IN_wbTag;
    logic [NW*DW-1:0]    IN_wbData;
    logic [NZ-1:0]       IN_zcValid;
    logic [NZ*TW-1:0]    IN_zcTag;
    logic [NZ*DW-1:0]    IN_zcData;
    logic                IN_invalidate;
    logic [SW-1:0]       IN_invalidateSqN;
    logic [NU*NF-1:0]    OUT_enableFU;

    int n_checks = 0;
    int n_fail   = 0;

    operand_load_stage dut (
        .clk(clk), .rst(rst),
        .IN_valid(IN_valid), .OUT_ready(OUT_ready),
        .IN_tagA(IN_tagA), .IN_tagB(IN_tagB), .IN_immA(IN_immA), .IN_immB(IN_immB),
        .IN_imm(IN_imm), .IN_pc(IN_pc), .IN_sqN(IN_sqN), .IN_fu(IN_fu), .IN_side(IN_side),
        .OUT_rfReadValid(OUT_rfReadValid), .OUT_rfReadAddr(OUT_rfReadAddr),
        .IN_rfReadData(IN_rfReadData),
        .IN_wbValid(IN_wbValid), .IN_wbTag(IN_wbTag), .IN_wbData(IN_wbData),
        .IN_zcValid(IN_zcValid), .IN_zcTag(IN_zcTag), .IN_zcData(IN_zcData),
        .IN_invalidate(IN_invalidate), .IN_invalidateSqN(IN_invalidateSqN),
        .OUT_valid(OUT_valid), .IN_fuReady(IN_fuReady),
        .OUT_srcA(OUT_srcA), .OUT_srcB(OUT_srcB), .OUT_imm(OUT_imm), .OUT_pc(OUT_pc),
        .OUT_sqN(OUT_sqN), .OUT_fu(OUT_fu), .OUT_side(OUT_side), .OUT_enableFU(OUT_enableFU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IN_valid = '0; IN_tagA = '0; IN_tagB = '0; IN_immA = '0; IN_immB = '0;
        IN_imm = '0; IN_pc = '0; IN_sqN = '0; IN_fu = '0; IN_side = '0;
        IN_rfReadData = '0; IN_wbValid = '0; IN_wbTag = '0; IN_wbData = '0;
        IN_zcValid = '0; IN_zcTag = '0; IN_zcData = '0;
        IN_invalidate = 1'b0; IN_invalidateSqN = '0; IN_fuReady = '1;
    endtask

    task automatic set_uop(input int l, input logic v, input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                           input logic ia, input logic ib, input logic [DW-1:0] imm, input logic [DW-1:0] pc,
                           input logic [SW-1:0] sq, input logic [FW-1:0] fu, input logic [SDW-1:0] side);
        IN_valid[l] = v; IN_tagA[l*TW +: TW] = ta; IN_tagB[l*TW +: TW] = tb;
        IN_immA[l] = ia; IN_immB[l] = ib; IN_imm[l*DW +: DW] = imm; IN_pc[l*DW +: DW] = pc;
        IN_sqN[l*SW +: SW] = sq; IN_fu[l*FW +: FW] = fu; IN_side[l*SDW +: SDW] = side;
    endtask

    task automatic drain();
        clear_inputs();
        tick();
        tick();
    endtask

    // Kill rule from modular arithmetic: younger when the wrapped distance lies in 1..2^(SW-1)-1.
    function automatic bit ref_younger(input int a, input int b);
        int d;
        d = (a - b) % 64;
        if (d < 0) d += 64;
        return (d >= 1) && (d <= 31);
    endfunction

    function automatic logic [DW-1:0] ref_operand(input int l, input bit isb);
        logic [TW-1:0] tag;
        logic [DW-1:0] v;
        bit found;
        tag = isb ? IN_tagB[l*TW +: TW] : IN_tagA[l*TW +: TW];
        found = 0;
        v = IN_rfReadData[(isb ? l + NU : l)*DW +: DW];
        if (isb ? IN_immB[l] : IN_immA[l]) begin
            v = isb ? IN_imm[l*DW +: DW] : IN_pc[l*DW +: DW];
            found = 1;
        end else if (tag == 0) begin
            v = 0;
            found = 1;
        end
`ifdef LOAD_ZC_FWD_EN
        for (int z = 0; z < NZ; z++)
            if (!found && IN_zcValid[z] && IN_zcTag[z*TW +: TW] == tag) begin
                v = IN_zcData[z*DW +: DW];
                found = 1;
            end
`endif
        for (int w = NW - 1; w >= 0; w--)
            if (!found && IN_wbValid[w] && IN_wbTag[w*TW +: TW] == tag) begin
                v = IN_wbData[w*DW +: DW];
                found = 1;
            end
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        n_checks++;
        if (OUT_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", OUT_valid); end
        n_checks++;
        if (OUT_enableFU !== '0) begin n_fail++; $display("FAIL reset_enableFU: got %h expected 0", OUT_enableFU); end
        n_checks++;
        if ({OUT_srcA, OUT_srcB, OUT_imm, OUT_pc, OUT_sqN, OUT_fu, OUT_side} !== '0) begin
            n_fail++; $display("FAIL reset_fields: got srcA=%h sqN=%h side=%h expected all 0", OUT_srcA, OUT_sqN, OUT_side);
        end
        n_checks++;
        if (OUT_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b expected 11", OUT_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bypass_priority();
        drain();
        set_uop(0, 1, 6'd5, 6'd7, 0, 0, 32'h0, 32'h0, 6'd3, 2'd0, 40'h0);
        IN_rfReadData[0 +: DW] = 32'h11;
        IN_wbValid = 3'b101;
        IN_wbTag   = {6'd5, 6'd9, 6'd5};
        IN_wbData  = {32'h33, 32'h0, 32'h22};
        IN_zcValid = 2'b10;
        IN_zcTag   = {6'd5, 6'd0};
        IN_zcData  = {32'h44, 32'h0};
        #1;
        n_checks++;
        if (OUT_rfReadAddr[0 +: TW] !== 6'd5) begin n_fail++; $display("FAIL rf_addr_a: got %0d expected 5", OUT_rfReadAddr[0 +: TW]); end
        tick();
        n_checks++;
`ifdef LOAD_ZC_FWD_EN
        if (OUT_srcA[0 +: DW] !== 32'h44) begin n_fail++; $display("FAIL bypass_prio: got %h expected 44", OUT_srcA[0 +: DW]); end
`else
        if (OUT_srcA[0 +: DW] !== 32'h33) begin n_fail++; $display("FAIL bypass_prio: got %h expected 33", OUT_srcA[0 +: DW]); end
`endif
        n_checks++;
        if (OUT_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b expected 1", OUT_valid[0]); end
    endtask

    task automatic test_tag0_imm();
        drain();
        set_uop(0, 1, 6'd9, 6'd0, 1, 0, 32'h0, 32'h1000, 6'd4, 2'd1, 40'h0);
        IN_rfReadData = {4{32'hDEAD}};
        IN_wbValid = 3'b001; IN_wbTag[0 +: TW] = 6'd0; IN_wbData[0 +: DW] = 32'hFF;
        #1;
        n_checks++;
        if (OUT_rfReadValid !== 4'b0100) begin n_fail++; $display("FAIL rf_read_valid: got %b expected 0100", OUT_rfReadValid); end
        tick();
        n_checks++;
        if (OUT_srcA[0 +: DW] !== 32'h1000) begin n_fail++; $display("FAIL imm_a: got %h expected 1000", OUT_srcA[0 +: DW]); end
        n_checks++;
        if (OUT_srcB[0 +: DW] !== 32'h0) begin n_fail++; $display("FAIL tag0_b: got %h expected 0", OUT_srcB[0 +: DW]); end
    endtask

    task automatic test_backpressure();
        drain();
        set_uop(0, 1, 6'd12, 6'd13, 0, 0, 32'h0, 32'h0, 6'd10, 2'd0, 40'h0);
        IN_rfReadData[0 +: DW] = 32'hAAAA;
        IN_fuReady[0] = 1'b0;
        tick();
        set_uop(0, 1, 6'd12, 6'd13, 0, 0, 32'h0, 32'h0, 6'd11, 2'd0, 40'h0);
        IN_rfReadData[0 +: DW] = 32'hBBBB;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (OUT_ready[0] !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d: got %b expected 0", c, OUT_ready[0]); end
            n_checks++;
            if (OUT_srcA[0 +: DW] !== 32'hAAAA || OUT_sqN[0 +: SW] !== 6'd10 || OUT_valid[0] !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold c%0d: got srcA=%h sqN=%0d v=%b expected AAAA 10 1", c, OUT_srcA[0 +: DW], OUT_sqN[0 +: SW], OUT_valid[0]);
            end
            tick();
        end
        IN_fuReady[0] = 1'b1;
        #1;
        n_checks++;
        if (OUT_ready[0] !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", OUT_ready[0]); end
        tick();
        n_checks++;
        if (OUT_srcA[0 +: DW] !== 32'hBBBB || OUT_sqN[0 +: SW] !== 6'd11) begin
            n_fail++; $display("FAIL next_uop: got srcA=%h sqN=%0d expected BBBB 11", OUT_srcA[0 +: DW], OUT_sqN[0 +: SW]);
        end
    endtask

    task automatic test_invalidate_wrap();
        drain();
        set_uop(0, 1, 6'd1, 6'd1, 0, 0, 32'h0, 32'h0, 6'd1, 2'd0, 40'h0);
        IN_fuReady[0] = 1'b0;
        tick();
        set_uop(0, 0, 6'd1, 6'd1, 0, 0, 32'h0, 32'h0, 6'd2, 2'd0, 40'h0);
        set_uop(1, 1, 6'd1, 6'd1, 0, 0, 32'h0, 32'h0, 6'd60, 2'd0, 40'h0);
        IN_invalidate = 1'b1; IN_invalidateSqN = 6'd62;
        tick();
        n_checks++;
        if (OUT_valid !== 2'b10 || OUT_sqN[SW +: SW] !== 6'd60) begin
            n_fail++; $display("FAIL inv_wrap: got valid=%b sqN1=%0d expected 10 60", OUT_valid, OUT_sqN[SW +: SW]);
        end
        drain();
        set_uop(0, 1, 6'd1, 6'd1, 0, 0, 32'h0, 32'h0, 6'd5, 2'd0, 40'h0);
        IN_fuReady[0] = 1'b0;
        tick();
        set_uop(0, 0, 6'd1, 6'd1, 0, 0, 32'h0, 32'h0, 6'd5, 2'd0, 40'h0);
        set_uop(1, 1, 6'd1, 6'd1, 0, 0, 32'h0, 32'h0, 6'd6, 2'd0, 40'h0);
        IN_invalidate = 1'b1; IN_invalidateSqN = 6'd5;
        tick();
        n_checks++;
        if (OUT_valid !== 2'b01) begin n_fail++; $display("FAIL inv_older: got valid=%b expected 01", OUT_valid); end
    endtask

    task automatic test_fu_decode();
        drain();
        set_uop(1, 1, 6'd3, 6'd4, 0, 0, 32'h0, 32'h0, 6'd20, 2'd2, 40'h0);
        tick();
        n_checks++;
        if (OUT_enableFU !== 8'b0100_0000) begin n_fail++; $display("FAIL fu_onehot: got %b expected 01000000", OUT_enableFU); end
        IN_valid = '0;
        tick();
        n_checks++;
        if (OUT_enableFU !== 8'b0) begin n_fail++; $display("FAIL fu_clear: got %b expected 0", OUT_enableFU); end
    endtask

    task automatic test_random();
        logic          m_valid [NU];
        logic [DW-1:0] m_a [NU], m_b [NU], m_imm [NU], m_pc [NU];
        logic [SW-1:0] m_sq [NU];
        logic [FW-1:0] m_fu [NU];
        logic [SDW-1:0] m_side [NU];
        logic [63:0]   r64;
        bit            exp_ready;
        drain();
        for (int l = 0; l < NU; l++) m_valid[l] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int l = 0; l < NU; l++) begin
                r64 = {$urandom, $urandom};
                set_uop(l, $urandom_range(0, 3) != 0, TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7)),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom,
                        SW'($urandom_range(0, 63)), FW'($urandom_range(0, 3)), r64[SDW-1:0]);
                IN_fuReady[l] = $urandom_range(0, 2) != 0;
            end
            for (int k = 0; k < 2 * NU; k++) IN_rfReadData[k*DW +: DW] = $urandom;
            for (int w = 0; w < NW; w++) begin
                IN_wbValid[w] = $urandom_range(0, 1); IN_wbTag[w*TW +: TW] = TW'($urandom_range(0, 7)); IN_wbData[w*DW +: DW] = $urandom;
            end
            for (int z = 0; z < NZ; z++) begin
                IN_zcValid[z] = $urandom_range(0, 1); IN_zcTag[z*TW +: TW] = TW'($urandom_range(0, 7)); IN_zcData[z*DW +: DW] = $urandom;
            end
            IN_invalidate = $urandom_range(0, 3) == 0;
            IN_invalidateSqN = SW'($urandom_range(0, 63));
            #1;
            for (int l = 0; l < NU; l++) begin
                exp_ready = !m_valid[l] || IN_fuReady[l];
                n_checks++;
                if (OUT_ready[l] !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc%0d lane%0d: got %b expected %b", cyc, l, OUT_ready[l], exp_ready); end
                n_checks++;
                if (OUT_rfReadValid[l] !== (IN_valid[l] & !IN_immA[l]) || OUT_rfReadValid[l+NU] !== (IN_valid[l] & !IN_immB[l])) begin
                    n_fail++; $display("FAIL rnd_rfvalid cyc%0d lane%0d: got %b", cyc, l, OUT_rfReadValid);
                end
                if (exp_ready && IN_valid[l] && !(IN_invalidate && ref_younger(int'(IN_sqN[l*SW +: SW]), int'(IN_invalidateSqN)))) begin
                    m_valid[l] = 1;
                    m_a[l] = ref_operand(l, 0); m_b[l] = ref_operand(l, 1);
                    m_imm[l] = IN_imm[l*DW +: DW]; m_pc[l] = IN_pc[l*DW +: DW];
                    m_sq[l] = IN_sqN[l*SW +: SW]; m_fu[l] = IN_fu[l*FW +: FW]; m_side[l] = IN_side[l*SDW +: SDW];
                end else if (exp_ready) begin
                    m_valid[l] = 0;
                end else if (IN_invalidate && ref_younger(int'(m_sq[l]), int'(IN_invalidateSqN))) begin
                    m_valid[l] = 0;
                end
            end
            tick();
            for (int l = 0; l < NU; l++) begin
                n_checks++;
                if (OUT_valid[l] !== m_valid[l]) begin n_fail++; $display("FAIL rnd_valid cyc%0d lane%0d: got %b expected %b", cyc, l, OUT_valid[l], m_valid[l]); end
                if (m_valid[l]) begin
                    n_checks++;
                    if (OUT_srcA[l*DW +: DW] !== m_a[l] || OUT_srcB[l*DW +: DW] !== m_b[l]) begin
                        n_fail++; $display("FAIL rnd_src cyc%0d lane%0d: got %h/%h expected %h/%h", cyc, l, OUT_srcA[l*DW +: DW], OUT_srcB[l*DW +: DW], m_a[l], m_b[l]);
                    end
                    n_checks++;
                    if (OUT_imm[l*DW +: DW] !== m_imm[l] || OUT_pc[l*DW +: DW] !== m_pc[l] || OUT_sqN[l*SW +: SW] !== m_sq[l] ||
                        OUT_fu[l*FW +: FW] !== m_fu[l] || OUT_side[l*SDW +: SDW] !== m_side[l]) begin
                        n_fail++; $display("FAIL rnd_fields cyc%0d lane%0d: got sqN=%0d fu=%0d expected %0d %0d", cyc, l, OUT_sqN[l*SW +: SW], OUT_fu[l*FW +: FW], m_sq[l], m_fu[l]);
                    end
                end
                n_checks++;
                if (OUT_enableFU[l*NF +: NF] !== (m_valid[l] ? NF'(1 << m_fu[l]) : NF'(0))) begin
                    n_fail++; $display("FAIL rnd_enableFU cyc%0d lane%0d: got %b", cyc, l, OUT_enableFU[l*NF +: NF]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_uop(0, 1, 6'd2, 6'd3, 0, 0, 32'h0, 32'h0, 6'd7, 2'd3, 40'h0);
        IN_fuReady[0] = 1'b0;
        tick();
        n_checks++;
        if (OUT_valid[0] !== 1'b1) begin n_fail++; $display("FAIL stall_loaded: got %b expected 1", OUT_valid[0]); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (OUT_valid !== 2'b00 || OUT_enableFU !== '0) begin
            n_fail++; $display("FAIL async_reset: got valid=%b enableFU=%b expected 0 0", OUT_valid, OUT_enableFU);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_bypass_priority();
        test_tag0_imm();
        test_backpressure();
        test_invalidate_wrap();
        test_fu_decode();
        test_random();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
